// File: rtl/mem_access_stage.sv
// RV32 memory-access stage: EX/MEM -> data bus -> MEM/WB, with bus timeout.
// Optional misalignment trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        MemtoReg,
  input  logic [31:0] result,
  input  logic [31:0] writeData,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] readData_out,
  output logic [31:0] result_out,
  output logic [4:0]  rd_out,
  output logic        bus_err,
  output logic        misalign_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        misal_q;
  logic        mem_op;
  logic        misal;
  logic        timeout;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] sh_w;
  logic [15:0] half;
  logic [31:0] ld_data;

  assign mem_op  = MemRead | MemWrite;
  assign timeout = (cnt == 8'(TIMEOUT_CYCLES - 1));
  assign misalign_out = misal_q;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misal = funct3[1] ? (result[1:0] != 2'b00)
                           : (funct3[0] & result[0]);
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op && !misal) state_n = BUSY;
        stall = !rst && mem_op && !misal;
      end
      BUSY: begin
        if (dmem_ack || timeout) state_n = IDLE;
        stall = !rst && !dmem_ack && !timeout;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // store lane steering
  always_comb begin
    be_n = 4'b0001 << result[1:0];
    wd_n = {4{writeData[7:0]}};
    unique case (1'b1)
      funct3[1]: begin
        be_n = 4'b1111;
        wd_n = writeData;
      end
      !funct3[1] && funct3[0]: begin
        be_n = result[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{writeData[15:0]}};
      end
      default: ;
    endcase
  end

  // load lane extraction
  always_comb begin
    sh_w    = dmem_rdata >> {lo_q, 3'b000};
    half    = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = dmem_rdata;
    unique case (1'b1)
      f3_q == 3'b000: ld_data = {{24{sh_w[7]}}, sh_w[7:0]};
      f3_q == 3'b100: ld_data = {24'b0, sh_w[7:0]};
      f3_q == 3'b001: ld_data = {{16{half[15]}}, half};
      f3_q == 3'b101: ld_data = {16'b0, half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      f3_q         <= '0;
      lo_q         <= '0;
      misal_q      <= 1'b0;
      bus_err      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
      readData_out <= '0;
      result_out   <= '0;
      rd_out       <= '0;
    end else begin
      bus_err <= 1'b0;
      misal_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            readData_out <= '0;
            if (misal) begin
              misal_q <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite;
              dmem_addr  <= {result[31:2], 2'b00};
              dmem_be    <= be_n;
              dmem_wdata <= wd_n;
              f3_q       <= funct3;
              lo_q       <= result[1:0];
              cnt        <= '0;
            end
          end else begin
            RegWrite_out <= RegWrite;
            MemtoReg_out <= MemtoReg;
            readData_out <= '0;
            result_out   <= result;
            rd_out       <= rd;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            cnt          <= '0;
            RegWrite_out <= RegWrite;
            MemtoReg_out <= MemtoReg;
            readData_out <= dmem_we ? 32'b0 : ld_data;
            result_out   <= result;
            rd_out       <= rd;
          end else begin
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            readData_out <= '0;
            if (timeout) begin
              dmem_req <= 1'b0;
              bus_err  <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a transaction-level expectation
// model and a single negedge compare process.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemWrite, MemRead, MemtoReg;
  logic [31:0] result, writeData;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] readData_out, result_out;
  logic [4:0]  rd_out;
  logic        bus_err, misalign_out;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemtoReg(MemtoReg),
    .result(result), .writeData(writeData),
    .rd(rd), .funct3(funct3), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .readData_out(readData_out), .result_out(result_out),
    .rd_out(rd_out), .bus_err(bus_err),
    .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // expectations for the current cycle
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_berr, e_mis;
  int          e_dm, e_wb;
  logic        e_we;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be;
  logic        e_rw, e_m2r;
  logic [31:0] e_res, e_rdat;
  logic [4:0]  e_rd;

  // what MEM/WB must show one cycle later
  int          p_kind;
  logic        p_rw, p_m2r, p_berr, p_mis, p_dmz;
  logic [31:0] p_res, p_rdat;
  logic [4:0]  p_rd;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", {31'b0, stall}, {31'b0, e_stall});
      cmp("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
      cmp("bus_err", {31'b0, bus_err}, {31'b0, e_berr});
      cmp("misalign_out", {31'b0, misalign_out}, {31'b0, e_mis});
      if (e_dm > 0) begin
        cmp("dmem_addr", dmem_addr, e_addr);
        cmp("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
      end
      if (e_dm > 1) begin
        cmp("dmem_be", {28'b0, dmem_be}, {28'b0, e_be});
        cmp("dmem_wdata", dmem_wdata, e_wd);
      end
      if (e_wb > 0) begin
        cmp("RegWrite_out", {31'b0, RegWrite_out}, {31'b0, e_rw});
        cmp("MemtoReg_out", {31'b0, MemtoReg_out}, {31'b0, e_m2r});
      end
      if (e_wb > 1) begin
        cmp("result_out", result_out, e_res);
        cmp("rd_out", {27'b0, rd_out}, {27'b0, e_rd});
        cmp("readData_out", readData_out, e_rdat);
      end
    end
  end

  function automatic logic [31:0] ld_val(input logic [2:0] f3,
      input logic [1:0] lo, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int          sh;
    sh = int'(lo) * 8;
    b  = w[sh +: 8];
    h  = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] st_be(input logic [2:0] f3,
      input logic [1:0] lo);
    if (f3[1]) return 4'b1111;
    if (f3[0]) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'(1 << lo);
  endfunction

  function automatic logic [31:0] st_wd(input logic [2:0] f3,
      input logic [31:0] w);
    if (f3[1]) return w;
    if (f3[0]) return {w[15:0], w[15:0]};
    return {w[7:0], w[7:0], w[7:0], w[7:0]};
  endfunction

  task automatic set_pend(input int k, input logic rw, m2r,
      input logic [31:0] res, input logic [4:0] rdn,
      input logic [31:0] rdat, input logic berr, mis, dmz);
    p_kind = k; p_rw = rw; p_m2r = m2r; p_res = res; p_rd = rdn;
    p_rdat = rdat; p_berr = berr; p_mis = mis; p_dmz = dmz;
  endtask

  task automatic take_pend();
    e_wb = p_kind; e_rw = p_rw; e_m2r = p_m2r; e_res = p_res;
    e_rd = p_rd; e_rdat = p_rdat; e_berr = p_berr; e_mis = p_mis;
    if (p_dmz) begin
      e_dm = 2; e_addr = '0; e_we = 1'b0; e_be = '0; e_wd = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic rw, m2r, input logic [31:0] res,
      input logic [4:0] rdn);
    RegWrite = rw; MemtoReg = m2r; MemRead = 1'b0; MemWrite = 1'b0;
    result = res; rd = rdn; funct3 = 3'b010; writeData = $urandom();
    e_stall = 1'b0; e_req = 1'b0; e_dm = 0;
    take_pend();
    set_pend(2, rw, m2r, res, rdn, 32'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic mem(input logic rdv, wrv, rw, m2r,
      input logic [2:0] f3, input logic [31:0] res, wd,
      input logic [4:0] rdn, input logic [31:0] rdat,
      input int waits, input int rst_at);
    logic mis, ack, to;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = f3[1] ? (res[1:0] != 2'b00) : (f3[0] & res[0]);
`else
    mis = 1'b0;
`endif
    RegWrite = rw; MemtoReg = m2r; MemRead = rdv; MemWrite = wrv;
    funct3 = f3; result = res; writeData = wd; rd = rdn;
    dmem_ack = 1'b0;
    e_stall = !mis; e_req = 1'b0; e_dm = 0;
    take_pend();
    set_pend(1, 1'b0, 1'b0, 32'b0, 5'b0, 32'b0, 1'b0, mis, 1'b0);
    tick();
    if (mis) return;
    for (int k = 0; k < TO; k++) begin
      ack = (k == waits);
      to  = (k == TO - 1);
      dmem_ack   = ack;
      dmem_rdata = ack ? rdat : $urandom();
      e_req  = 1'b1;
      e_dm   = wrv ? 2 : 1;
      e_addr = {res[31:2], 2'b00};
      e_we   = wrv;
      e_be   = st_be(f3, res[1:0]);
      e_wd   = st_wd(f3, wd);
      take_pend();
      if (k == rst_at) begin
        rst = 1'b1;
        e_stall = 1'b0;
        set_pend(2, 1'b0, 1'b0, 32'b0, 5'b0, 32'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        dmem_ack = 1'b0;
        return;
      end
      e_stall = !ack && !to;
      if (ack)
        set_pend(2, rw, m2r, res, rdn,
                 wrv ? 32'b0 : ld_val(f3, res[1:0], rdat),
                 1'b0, 1'b0, 1'b0);
      else
        set_pend(1, 1'b0, 1'b0, 32'b0, 5'b0, 32'b0, to, 1'b0, 1'b0);
      tick();
      if (ack || to) break;
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    RegWrite = 1'b1; MemtoReg = 1'b0; MemRead = 1'b1; MemWrite = 1'b0;
    result = 32'h40; writeData = '0; rd = 5'd3; funct3 = 3'b010;
    dmem_ack = 1'b0; dmem_rdata = '0;

    // model pins against hand-computed literals
    cmp("pin_lb", ld_val(3'b000, 2'b11, 32'h80AABBCC), 32'hFFFFFF80);
    cmp("pin_lbu", ld_val(3'b100, 2'b01, 32'h11223344), 32'h00000033);
    cmp("pin_lh", ld_val(3'b001, 2'b10, 32'h80017FFF), 32'hFFFF8001);
    cmp("pin_lhu", ld_val(3'b101, 2'b00, 32'h1234F00D), 32'h0000F00D);
    cmp("pin_sh_be", {28'b0, st_be(3'b001, 2'b10)}, 32'h0000000C);
    cmp("pin_sh_wd", st_wd(3'b001, 32'h0000BEEF), 32'hBEEFBEEF);
    cmp("pin_sb_be", {28'b0, st_be(3'b000, 2'b11)}, 32'h00000008);

    // reset with a memory op presented: stall must stay low
    set_pend(2, 1'b0, 1'b0, 32'b0, 5'b0, 32'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_en = 1'b1;
    repeat (2) begin
      e_stall = 1'b0; e_req = 1'b0; e_dm = 0;
      take_pend();
      tick();
    end
    rst = 1'b0;

    alu(1'b1, 1'b0, 32'h1234, 5'd5);
    alu(1'b1, 1'b1, 32'hA5A5_0001, 5'd31);
    // LB, three BUSY cycles without ack
    mem(1, 0, 1, 1, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80AABBCC, 3, -1);
    // SH, immediate ack
    mem(0, 1, 0, 0, 3'b001, 32'h202, 32'h0000BEEF, 5'd0, 32'h0, 0, -1);
    // LW with no ack: bus error
    mem(1, 0, 1, 1, 3'b010, 32'h100, 32'h0, 5'd9, 32'h0, -1, -1);
    alu(1'b0, 1'b0, 32'h0, 5'd0);
    mem(1, 0, 1, 1, 3'b100, 32'h101, 32'h0, 5'd10, 32'h11223344, 1, -1);
    mem(1, 0, 1, 1, 3'b001, 32'h102, 32'h0, 5'd11, 32'h80017FFF, 2, -1);
    mem(1, 0, 1, 1, 3'b101, 32'h100, 32'h0, 5'd12, 32'h1234F00D, 0, -1);
    mem(1, 0, 1, 1, 3'b010, 32'h104, 32'h0, 5'd13, 32'hDEADBEEF, 0, -1);
    mem(1, 0, 1, 1, 3'b111, 32'h108, 32'h0, 5'd14, 32'hCAFEF00D, 1, -1);
    mem(0, 1, 0, 0, 3'b000, 32'h3, 32'h123456A5, 5'd0, 32'h0, 0, -1);
    // read+write together behaves as store
    mem(1, 1, 1, 1, 3'b010, 32'h10, 32'h89ABCDEF, 5'd15, 32'h5555, 1, -1);
    // ack on the timeout cycle wins
    mem(1, 0, 1, 1, 3'b010, 32'h200, 32'h0, 5'd16, 32'h0BADF00D, TO - 1, -1);
    // ack while idle must be ignored
    dmem_ack = 1'b1;
    alu(1'b1, 1'b0, 32'h77, 5'd17);
    dmem_ack = 1'b0;
    // misaligned word load
    mem(1, 0, 1, 1, 3'b010, 32'h101, 32'h0, 5'd18, 32'h01020304, 0, -1);
    alu(1'b1, 1'b0, 32'h88, 5'd19);
    // reset in second BUSY cycle, ack arrives late
    mem(1, 0, 1, 1, 3'b010, 32'h300, 32'h0, 5'd20, 32'h0, -1, 1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    alu(1'b1, 1'b0, 32'h99, 5'd21);
    dmem_ack = 1'b0;
    alu(1'b0, 1'b0, 32'h0, 5'd0);
    alu(1'b0, 1'b0, 32'h0, 5'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
